// File: rtl/wb_cp0_stage.sv
// Write-back stage of the 5-stage MIPS pipeline: register-file write port, HI/LO, CP0 Status/Cause/EPC,
// SYSCALL/ERET redirect. Define WB_CP0_COUNT_EN to add the free-running CP0 Count register (8'h48).
module wb_cp0_stage #(
  parameter logic [31:0] EXC_ENTRY  = 32'h0000_0100,
  parameter logic [4:0]  EXCODE_SYS = 5'd8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         WB_valid,
  input  logic [117:0] MEM_WB_bus_r,
  output logic         rf_wen,
  output logic [4:0]   rf_wdest,
  output logic [31:0]  rf_wdata,
  output logic         WB_over,
  output logic [4:0]   WB_wdest,
  output logic         exc_valid,
  output logic [31:0]  exc_pc,
  output logic         cancel,
  output logic [31:0]  WB_pc
);

  localparam logic [7:0] ADDR_STATUS = 8'h60;
  localparam logic [7:0] ADDR_CAUSE  = 8'h68;
  localparam logic [7:0] ADDR_EPC    = 8'h70;
  localparam logic [7:0] ADDR_COUNT  = 8'h48;

  logic        bus_rf_wen;
  logic [4:0]  bus_wdest;
  logic [31:0] mem_result, lo_result, pc;
  logic        hi_write, lo_write, mfhi, mflo, mtc0, mfc0, syscall, eret;
  logic [7:0]  cp0r_addr;

  assign {bus_rf_wen, bus_wdest, mem_result, lo_result, hi_write, lo_write,
          mfhi, mflo, mtc0, mfc0, cp0r_addr, syscall, eret, pc} = MEM_WB_bus_r;

  // An instruction held in WB while reset is asserted is discarded entirely.
  logic valid;
  assign valid = WB_valid & ~reset;

  logic [31:0] hi_q, hi_d, lo_q, lo_d, epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d;
  logic [1:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
`ifdef WB_CP0_COUNT_EN
  logic [31:0] count_q, count_d;
`endif

  logic [31:0] cp0_rdata;
  logic        take_sys, take_eret;

  assign take_sys  = valid & syscall;
  assign take_eret = valid & eret & ~syscall;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cp0_rdata = '0;
    case (cp0r_addr)
      ADDR_STATUS: cp0_rdata = {16'b0, im_q, 6'b0, exl_q, ie_q};
      ADDR_CAUSE:  cp0_rdata = {22'b0, ip_q, 1'b0, exccode_q, 2'b0};
      ADDR_EPC:    cp0_rdata = epc_q;
`ifdef WB_CP0_COUNT_EN
      ADDR_COUNT:  cp0_rdata = count_q;
`endif
      default:     cp0_rdata = '0;
    endcase
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    epc_d     = epc_q;
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    ip_d      = ip_q;
    exccode_d = exccode_q;
`ifdef WB_CP0_COUNT_EN
    count_d   = count_q + 32'd1;
`endif
    if (valid && hi_write) hi_d = mem_result;
    if (valid && lo_write) lo_d = lo_result;
    if (valid && mtc0) begin
      case (cp0r_addr)
        ADDR_STATUS: begin
          im_d  = mem_result[15:8];
          exl_d = mem_result[1];
          ie_d  = mem_result[0];
        end
        ADDR_CAUSE:  ip_d  = mem_result[9:8];
        ADDR_EPC:    epc_d = mem_result;
`ifdef WB_CP0_COUNT_EN
        ADDR_COUNT:  count_d = mem_result;
`endif
        default: ;
      endcase
    end
    // A nested syscall keeps the original return address.
    if (take_sys) begin
      exccode_d = EXCODE_SYS;
      if (!exl_q) epc_d = pc;
      exl_d = 1'b1;
    end else if (take_eret) begin
      exl_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      epc_q     <= '0;
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      ip_q      <= '0;
      exccode_q <= '0;
`ifdef WB_CP0_COUNT_EN
      count_q   <= '0;
`endif
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      epc_q     <= epc_d;
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
`ifdef WB_CP0_COUNT_EN
      count_q   <= count_d;
`endif
    end
  end

  always_comb begin
    rf_wdata = '0;
    if (valid) begin
      if (mfhi)      rf_wdata = hi_q;
      else if (mflo) rf_wdata = lo_q;
      else if (mfc0) rf_wdata = cp0_rdata;
      else           rf_wdata = mem_result;
    end
  end

  always_comb begin
    exc_pc = '0;
    if (take_sys)       exc_pc = EXC_ENTRY;
    else if (take_eret) exc_pc = epc_q;
  end

  assign rf_wen    = valid & bus_rf_wen;
  assign rf_wdest  = bus_wdest & {5{valid}};
  assign WB_wdest  = rf_wdest;
  assign WB_over   = valid;
  assign exc_valid = take_sys | take_eret;
  assign cancel    = exc_valid;
  assign WB_pc     = pc;

endmodule

// File: tb/tb_wb_cp0_stage.sv
// Directed table-driven bench for wb_cp0_stage plus hand-written reset sequence.
module tb_wb_cp0_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         WB_valid;
  logic [117:0] MEM_WB_bus_r;
  logic         rf_wen, WB_over, exc_valid, cancel;
  logic [4:0]   rf_wdest, WB_wdest;
  logic [31:0]  rf_wdata, exc_pc, WB_pc;

  wb_cp0_stage dut (
    .clk(clk), .reset(reset), .WB_valid(WB_valid), .MEM_WB_bus_r(MEM_WB_bus_r),
    .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata), .WB_over(WB_over),
    .WB_wdest(WB_wdest), .exc_valid(exc_valid), .exc_pc(exc_pc), .cancel(cancel),
    .WB_pc(WB_pc)
  );

  always #5 clk = ~clk;

  typedef enum {K_IDLE, K_ALU, K_MULT, K_MFHI, K_MFLO, K_MTC0, K_MFC0, K_SYS, K_ERET, K_BOTH} kind_e;

  typedef struct {
    kind_e       kind;
    logic [4:0]  dest;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [7:0]  addr;
    logic [31:0] pc;
    logic [31:0] e_wdata;
    logic [31:0] e_excpc;
  } vec_t;

  localparam logic [7:0] A_ST = 8'h60, A_CA = 8'h68, A_EPC = 8'h70, A_CNT = 8'h48;
`ifdef WB_CP0_COUNT_EN
  localparam logic [31:0] CNT_EXP = 32'h0000_0005;
`else
  localparam logic [31:0] CNT_EXP = 32'h0000_0000;
`endif

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  function automatic vec_t mk(kind_e k, logic [4:0] dest, logic [31:0] d1, logic [31:0] d2,
                              logic [7:0] addr, logic [31:0] pc, logic [31:0] e_wdata,
                              logic [31:0] e_excpc);
    vec_t v;
    v.kind = k; v.dest = dest; v.d1 = d1; v.d2 = d2; v.addr = addr; v.pc = pc;
    v.e_wdata = e_wdata; v.e_excpc = e_excpc;
    return v;
  endfunction

  function automatic logic [117:0] pack(logic wen, logic [4:0] d, logic [31:0] m, logic [31:0] lo,
                                        logic hw, logic lw, logic fh, logic fl, logic mt, logic mf,
                                        logic [7:0] a, logic sy, logic er, logic [31:0] pc);
    return {wen, d, m, lo, hw, lw, fh, fl, mt, mf, a, sy, er, pc};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    WB_valid = (v.kind != K_IDLE);
    case (v.kind)
      K_IDLE: MEM_WB_bus_r = pack(1, v.dest, v.d1, v.d2, 1, 1, 0, 0, 0, 0, v.addr, 1, 0, v.pc);
      K_ALU:  MEM_WB_bus_r = pack(1, v.dest, v.d1, v.d2, 0, 0, 0, 0, 0, 0, v.addr, 0, 0, v.pc);
      K_MULT: MEM_WB_bus_r = pack(0, v.dest, v.d1, v.d2, 1, 1, 0, 0, 0, 0, v.addr, 0, 0, v.pc);
      K_MFHI: MEM_WB_bus_r = pack(1, v.dest, v.d1, v.d2, 0, 0, 1, 0, 0, 0, v.addr, 0, 0, v.pc);
      K_MFLO: MEM_WB_bus_r = pack(1, v.dest, v.d1, v.d2, 0, 0, 0, 1, 0, 0, v.addr, 0, 0, v.pc);
      K_MTC0: MEM_WB_bus_r = pack(0, v.dest, v.d1, v.d2, 0, 0, 0, 0, 1, 0, v.addr, 0, 0, v.pc);
      K_MFC0: MEM_WB_bus_r = pack(1, v.dest, v.d1, v.d2, 0, 0, 0, 0, 0, 1, v.addr, 0, 0, v.pc);
      K_SYS:  MEM_WB_bus_r = pack(0, v.dest, v.d1, v.d2, 0, 0, 0, 0, 0, 0, v.addr, 1, 0, v.pc);
      K_ERET: MEM_WB_bus_r = pack(0, v.dest, v.d1, v.d2, 0, 0, 0, 0, 0, 0, v.addr, 0, 1, v.pc);
      default: MEM_WB_bus_r = pack(0, v.dest, v.d1, v.d2, 0, 0, 0, 0, 0, 0, v.addr, 1, 1, v.pc);
    endcase
  endtask

  task automatic check_row(vec_t v, string tag);
    logic       e_valid, e_wen, e_exc;
    logic [4:0] e_dest;
    e_valid = (v.kind != K_IDLE);
    e_wen   = v.kind inside {K_ALU, K_MFHI, K_MFLO, K_MFC0};
    e_exc   = v.kind inside {K_SYS, K_ERET, K_BOTH};
    e_dest  = e_valid ? v.dest : 5'd0;
    check({tag, ".rf_wdata"},  rf_wdata,          v.e_wdata);
    check({tag, ".rf_wen"},    {31'b0, rf_wen},   {31'b0, e_wen});
    check({tag, ".rf_wdest"},  {27'b0, rf_wdest}, {27'b0, e_dest});
    check({tag, ".WB_wdest"},  {27'b0, WB_wdest}, {27'b0, e_dest});
    check({tag, ".WB_over"},   {31'b0, WB_over},  {31'b0, e_valid});
    check({tag, ".exc_valid"}, {31'b0, exc_valid}, {31'b0, e_exc});
    check({tag, ".cancel"},    {31'b0, cancel},   {31'b0, e_exc});
    check({tag, ".exc_pc"},    exc_pc,            v.e_excpc);
    check({tag, ".WB_pc"},     WB_pc,             v.pc);
  endtask

  task automatic run(vec_t v, string tag);
    @(negedge clk);
    apply(v);
    #1;
    check_row(v, tag);
  endtask

  initial begin
    reset = 1'b1;
    WB_valid = 1'b0;
    MEM_WB_bus_r = '0;

    //        kind    dest  d1             d2            addr   pc             e_wdata        e_excpc
    vecs.push_back(mk(K_IDLE, 5'd3, 32'h0000_AAAA, 32'h0,        A_ST,  32'h0000_1000, 32'h0,         32'h0));
    vecs.push_back(mk(K_MFHI, 5'd3, 32'hDEAD_0000, 32'h0,        A_ST,  32'h0000_1004, 32'h0,         32'h0));
    vecs.push_back(mk(K_MFLO, 5'd3, 32'hDEAD_0000, 32'h0,        A_ST,  32'h0000_1008, 32'h0,         32'h0));
    vecs.push_back(mk(K_MFC0, 5'd4, 32'hDEAD_0000, 32'h0,        A_ST,  32'h0000_100C, 32'h0,         32'h0));
    vecs.push_back(mk(K_MFC0, 5'd4, 32'hDEAD_0000, 32'h0,        A_CA,  32'h0000_1010, 32'h0,         32'h0));
    vecs.push_back(mk(K_MFC0, 5'd4, 32'hDEAD_0000, 32'h0,        A_EPC, 32'h0000_1014, 32'h0,         32'h0));
    vecs.push_back(mk(K_MULT, 5'd0, 32'h0000_1234, 32'h0000_5678, A_ST, 32'h0000_1018, 32'h0000_1234, 32'h0));
    vecs.push_back(mk(K_MFHI, 5'd3, 32'hDEAD_BEEF, 32'h0,        A_ST,  32'h0000_101C, 32'h0000_1234, 32'h0));
    vecs.push_back(mk(K_MFLO, 5'd3, 32'hDEAD_BEEF, 32'h0,        A_ST,  32'h0000_1020, 32'h0000_5678, 32'h0));
    vecs.push_back(mk(K_ALU,  5'd7, 32'hCAFE_BABE, 32'h0,        A_ST,  32'h0000_1024, 32'hCAFE_BABE, 32'h0));
    vecs.push_back(mk(K_MTC0, 5'd0, 32'hFFFF_FFFF, 32'h0,        A_ST,  32'h0000_1028, 32'hFFFF_FFFF, 32'h0));
    vecs.push_back(mk(K_MFC0, 5'd2, 32'h0,         32'h0,        A_ST,  32'h0000_102C, 32'h0000_FF03, 32'h0));
    vecs.push_back(mk(K_MTC0, 5'd0, 32'h0,         32'h0,        A_ST,  32'h0000_1030, 32'h0,         32'h0));
    vecs.push_back(mk(K_MTC0, 5'd0, 32'hFFFF_FFFF, 32'h0,        A_CA,  32'h0000_1034, 32'hFFFF_FFFF, 32'h0));
    vecs.push_back(mk(K_MFC0, 5'd2, 32'h0,         32'h0,        A_CA,  32'h0000_1038, 32'h0000_0300, 32'h0));
    vecs.push_back(mk(K_MTC0, 5'd0, 32'h0,         32'h0,        A_CA,  32'h0000_103C, 32'h0,         32'h0));
    vecs.push_back(mk(K_SYS,  5'd0, 32'h0,         32'h0,        8'h0,  32'h0000_0040, 32'h0,         32'h0000_0100));
    vecs.push_back(mk(K_MFC0, 5'd2, 32'h0,         32'h0,        A_EPC, 32'h0000_0100, 32'h0000_0040, 32'h0));
    vecs.push_back(mk(K_MFC0, 5'd2, 32'h0,         32'h0,        A_CA,  32'h0000_0104, 32'h0000_0020, 32'h0));
    vecs.push_back(mk(K_MFC0, 5'd2, 32'h0,         32'h0,        A_ST,  32'h0000_0108, 32'h0000_0002, 32'h0));
    vecs.push_back(mk(K_SYS,  5'd0, 32'h0,         32'h0,        8'h0,  32'h0000_0104, 32'h0,         32'h0000_0100));
    vecs.push_back(mk(K_MFC0, 5'd2, 32'h0,         32'h0,        A_EPC, 32'h0000_0100, 32'h0000_0040, 32'h0));
    vecs.push_back(mk(K_MTC0, 5'd0, 32'h0000_0044, 32'h0,        A_EPC, 32'h0000_0104, 32'h0000_0044, 32'h0));
    vecs.push_back(mk(K_ERET, 5'd0, 32'h0,         32'h0,        8'h0,  32'h0000_0108, 32'h0,         32'h0000_0044));
    vecs.push_back(mk(K_IDLE, 5'd0, 32'h0,         32'h0,        8'h0,  32'h0000_0044, 32'h0,         32'h0));
    vecs.push_back(mk(K_MFC0, 5'd2, 32'h0,         32'h0,        A_ST,  32'h0000_0048, 32'h0,         32'h0));
    vecs.push_back(mk(K_MTC0, 5'd0, 32'hFFFF_FFFE, 32'h0,        A_CNT, 32'h0000_004C, 32'hFFFF_FFFE, 32'h0));
    vecs.push_back(mk(K_IDLE, 5'd0, 32'h0,         32'h0,        8'h0,  32'h0000_0050, 32'h0,         32'h0));
    vecs.push_back(mk(K_IDLE, 5'd0, 32'h0,         32'h0,        8'h0,  32'h0000_0054, 32'h0,         32'h0));
    vecs.push_back(mk(K_MFC0, 5'd5, 32'h0,         32'h0,        A_CNT, 32'h0000_0058, 32'h0,         32'h0));
    vecs.push_back(mk(K_MTC0, 5'd0, 32'h0000_0005, 32'h0,        A_CNT, 32'h0000_005C, 32'h0000_0005, 32'h0));
    vecs.push_back(mk(K_MFC0, 5'd5, 32'h0,         32'h0,        A_CNT, 32'h0000_0060, CNT_EXP,       32'h0));
    vecs.push_back(mk(K_BOTH, 5'd0, 32'h0,         32'h0,        8'h0,  32'h0000_0200, 32'h0,         32'h0000_0100));
    vecs.push_back(mk(K_MFC0, 5'd2, 32'h0,         32'h0,        A_EPC, 32'h0000_0100, 32'h0000_0200, 32'h0));

    // Outputs while reset is held with an idle WB stage.
    repeat (2) @(negedge clk);
    #1;
    check("por.rf_wdata",  rf_wdata, 32'h0);
    check("por.exc_valid", {31'b0, exc_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run(vecs[i], $sformatf("v%0d", i));

    // Reset asserted mid-instruction: the MULT must not reach HI/LO, outputs forced to 0.
    @(negedge clk);
    apply(mk(K_MULT, 5'd9, 32'h1111_1111, 32'h2222_2222, 8'h0, 32'h0000_0300, 32'h0, 32'h0));
    reset = 1'b1;
    #1;
    check("rst.rf_wdata", rf_wdata, 32'h0);
    check("rst.rf_wdest", {27'b0, rf_wdest}, 32'h0);
    check("rst.WB_over",  {31'b0, WB_over}, 32'h0);
    check("rst.WB_pc",    WB_pc, 32'h0000_0300);
    @(negedge clk);
    apply(mk(K_SYS, 5'd0, 32'h0, 32'h0, 8'h0, 32'h0000_0304, 32'h0, 32'h0));
    #1;
    check("rst.exc_valid", {31'b0, exc_valid}, 32'h0);
    check("rst.cancel",    {31'b0, cancel}, 32'h0);
    check("rst.exc_pc",    exc_pc, 32'h0);
    @(negedge clk);
    WB_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    run(mk(K_MFHI, 5'd3, 32'hDEAD_0000, 32'h0, 8'h0,  32'h0000_0400, 32'h0, 32'h0), "post.hi");
    run(mk(K_MFLO, 5'd3, 32'hDEAD_0000, 32'h0, 8'h0,  32'h0000_0404, 32'h0, 32'h0), "post.lo");
    run(mk(K_MFC0, 5'd3, 32'h0,         32'h0, A_EPC, 32'h0000_0408, 32'h0, 32'h0), "post.epc");
    run(mk(K_MFC0, 5'd3, 32'h0,         32'h0, A_ST,  32'h0000_040C, 32'h0, 32'h0), "post.status");
    run(mk(K_MFC0, 5'd3, 32'h0,         32'h0, A_CA,  32'h0000_0410, 32'h0, 32'h0), "post.cause");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
